// File: rtl/pool_pkg.sv
// Shared defaults and FSM encoding for the vertical stage of the 2x2 max-pool path.
package pool_pkg;

  localparam int unsigned POOL_DATA_W   = 20;
  localparam int unsigned POOL_MAX_COLS = 64;
  localparam int unsigned POOL_MAX_ROWS = 64;
  localparam int unsigned POOL_COL_W    = $clog2(POOL_MAX_COLS + 1);
  localparam int unsigned POOL_ROW_W    = $clog2(POOL_MAX_ROWS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StEven,
    StOdd,
    StFlush,
    StFin
  } pool_state_e;

endpackage

// File: rtl/pool_line_buf.sv
// One row of horizontal maxima: synchronous write, combinational read, no reset on the array.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = POOL_DATA_W,
  parameter int unsigned DEPTH  = POOL_MAX_COLS,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_row_merger.sv
// Vertical 2x2 max-pool stage: buffers even rows, merges odd rows against them.
// Define POOL_ODD_FLUSH_EN to emit a trailing unpaired row unmodified (ceil mode).
module pool_row_merger
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W   = POOL_DATA_W,
  parameter int unsigned MAX_COLS = POOL_MAX_COLS,
  parameter int unsigned MAX_ROWS = POOL_MAX_ROWS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_COLS+1)-1:0]   cols,
  input  logic [$clog2(MAX_ROWS+1)-1:0]   rows,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  output logic [DATA_W-1:0]               out_data,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned CW = $clog2(MAX_COLS + 1);
  localparam int unsigned RW = $clog2(MAX_ROWS + 1);
  localparam int unsigned AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  pool_state_e       state_q;
  logic [CW-1:0]     cols_q, col_cnt_q;
  logic [RW-1:0]     rows_q, row_cnt_q;
  logic [DATA_W-1:0] rd_data;
  logic              buf_we, col_last, row_last;

  assign buf_we   = (state_q == StEven) && in_valid;
  assign col_last = (col_cnt_q == cols_q - CW'(1));
  assign row_last = (row_cnt_q == rows_q - RW'(1));

  // Write and read share the column index; the read is combinational so the
  // odd-row compare finishes in the accept cycle.
  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_COLS)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (col_cnt_q[AW-1:0]),
    .wdata (in_data),
    .raddr (col_cnt_q[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cols_q    <= '0;
      rows_q    <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cols_q    <= cols;
            rows_q    <= rows;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            busy      <= 1'b1;
            state_q   <= StEven;
          end
        end
        StEven: begin
          if (in_valid) begin
            if (col_last) begin
              col_cnt_q <= '0;
              row_cnt_q <= row_cnt_q + RW'(1);
              if (!row_last) begin
                state_q <= StOdd;
              end else begin
`ifdef POOL_ODD_FLUSH_EN
                state_q <= StFlush;
`else
                state_q <= StFin;
`endif
              end
            end else begin
              col_cnt_q <= col_cnt_q + CW'(1);
            end
          end
        end
        StOdd: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= (in_data > rd_data) ? in_data : rd_data;
            if (col_last) begin
              col_cnt_q <= '0;
              row_cnt_q <= row_cnt_q + RW'(1);
              state_q   <= row_last ? StFin : StEven;
            end else begin
              col_cnt_q <= col_cnt_q + CW'(1);
            end
          end
        end
`ifdef POOL_ODD_FLUSH_EN
        StFlush: begin
          // col_cnt_q is zero on entry and walks the stored row once.
          out_valid <= 1'b1;
          out_data  <= rd_data;
          if (col_last) begin
            col_cnt_q <= '0;
            state_q   <= StFin;
          end else begin
            col_cnt_q <= col_cnt_q + CW'(1);
          end
        end
`endif
        StFin: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_row_merger.sv
// Scoreboard bench for pool_row_merger: random frames checked against a row-pair max model.
module tb_pool_row_merger;

  localparam int unsigned DW   = 20;
  localparam int unsigned MC   = 64;
  localparam int unsigned MR   = 64;
  localparam int unsigned CW   = $clog2(MC + 1);
  localparam int unsigned RW   = $clog2(MR + 1);
  localparam longint      T    = 10;
  localparam longint      HALF = 5;

  typedef logic [DW-1:0] word_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] cols = '0;
  logic [RW-1:0] rows = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_data[$];
  longint        exp_time[$];

  always #5 clk = ~clk;

  pool_row_merger #(
    .DATA_W   (DW),
    .MAX_COLS (MC),
    .MAX_ROWS (MR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cols      (cols),
    .rows      (rows),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  function automatic void check(input string name, input bit ok,
                                input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [DW-1:0] pmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [31:0] v;
    v = $urandom;
    case (v[3:2])
      2'd0:    return '0;
      2'd1:    return '1;
      default: return v[31:12];
    endcase
  endfunction

  // Pooled output list: column-wise max of each row pair, plus the unpaired row in ceil mode.
  function automatic void model(input int c, input int r, input word_q_t img);
    for (int rr = 0; rr + 1 < r; rr += 2)
      for (int cc = 0; cc < c; cc++)
        exp_data.push_back(pmax(img[rr*c+cc], img[(rr+1)*c+cc]));
`ifdef POOL_ODD_FLUSH_EN
    if (r % 2 == 1)
      for (int cc = 0; cc < c; cc++) exp_data.push_back(img[(r-1)*c+cc]);
`endif
  endfunction

  // Monitor: every out_valid pops one expected value and its expected sample time.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_data.size() == 0 || exp_time.size() == 0) begin
          check("unexpected_out_valid", 1'b0, {44'd0, out_data}, 64'd0);
        end else begin
          automatic logic [DW-1:0] d = exp_data.pop_front();
          automatic longint        t = exp_time.pop_front();
          check("out_data", out_data == d, {44'd0, out_data}, {44'd0, d});
          check("out_time", longint'($time) == t, $time, t);
        end
      end
    end
  end

  task automatic run_frame(input int c, input int r, input int gmax, input bit poke,
                           input word_q_t img);
    longint t_last, exp_done;
    bit     flush_odd, seen;
    int     g;
    model(c, r, img);
    flush_odd = 1'b0;
`ifdef POOL_ODD_FLUSH_EN
    flush_odd = (r % 2 == 1);
`endif
    @(posedge clk); #1;
    start = 1'b1; cols = CW'(c); rows = RW'(r);
    @(posedge clk); #1;
    start = 1'b0;
    cols = CW'($urandom_range(1, MC)); rows = RW'($urandom_range(1, MR));
    check("busy_after_start", busy == 1'b1, {63'd0, busy}, 64'd1);
    t_last = 0;
    for (int rr = 0; rr < r; rr++) begin
      for (int cc = 0; cc < c; cc++) begin
        if (poke && rr == 0 && cc == 1) begin
          start = 1'b1; cols = CW'(1); rows = RW'(1);
          @(posedge clk); #1;
          start = 1'b0;
        end
        g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = img[rr*c+cc];
        @(posedge clk);
        t_last = longint'($time);
        if (rr % 2 == 1) exp_time.push_back(t_last + HALF);
        #1;
        in_valid = 1'b0;
        in_data  = rnd_word();
      end
    end
    if (flush_odd)
      for (int k = 0; k < c; k++) exp_time.push_back(t_last + longint'(k + 1) * T + HALF);
    exp_done = t_last + (flush_odd ? longint'(c) + 1 : 1) * T + HALF;
    seen = 1'b0;
    for (int n = 0; n < c + 8 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_time", seen && longint'($time) == exp_done, $time, exp_done);
    check("busy_low_at_done", busy == 1'b0, {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("done_single_cycle", done == 1'b0, {63'd0, done}, 64'd0);
    #1;
    check("scoreboard_drained", exp_data.size() == 0 && exp_time.size() == 0,
          64'(exp_data.size() + exp_time.size()), 64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t q;
    int      c, r;

    #2 rst_n = 1'b0;
    #20;
    check("rst_out_valid", out_valid == 1'b0, {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data == '0, {44'd0, out_data}, 64'd0);
    check("rst_busy", busy == 1'b0, {63'd0, busy}, 64'd0);
    check("rst_done", done == 1'b0, {63'd0, done}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Beats in IDLE must be dropped silently.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = rnd_word();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("idle_busy", busy == 1'b0, {63'd0, busy}, 64'd0);

    q = '{20'h5, 20'h9, 20'h2, 20'h7, 20'h6, 20'h1, 20'h8, 20'h7};
    run_frame(4, 2, 0, 1'b0, q);

    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(rnd_word());
    run_frame(2, 4, 3, 1'b1, q);

    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(rnd_word());
    q.push_back(20'h4); q.push_back(20'h0); q.push_back(20'hFFFFF);
    run_frame(3, 3, 0, 1'b0, q);

    q = '{20'h3A, 20'h0, 20'h3A, 20'hFFFFF};
    run_frame(2, 2, 1, 1'b0, q);

    // Abort mid odd row: the second odd result must never appear.
    @(posedge clk); #1;
    start = 1'b1; cols = CW'(4); rows = RW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(10 * (i + 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 20'd15;
    exp_data.push_back(20'd15);
    @(posedge clk);
    exp_time.push_back(longint'($time) + HALF);
    #1;
    in_valid = 1'b1; in_data = 20'd99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid == 1'b0, {63'd0, out_valid}, 64'd0);
    check("abort_out_data", out_data == '0, {44'd0, out_data}, 64'd0);
    check("abort_busy", busy == 1'b0, {63'd0, busy}, 64'd0);
    check("abort_done", done == 1'b0, {63'd0, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_sb_drained", exp_data.size() == 0 && exp_time.size() == 0,
          64'(exp_data.size() + exp_time.size()), 64'd0);

    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(rnd_word());
    run_frame(4, 2, 2, 1'b0, q);

    for (int f = 0; f < 20; f++) begin
      c = (f == 7) ? int'(MC) : int'($urandom_range(1, 8));
      r = int'($urandom_range(1, 5));
      q.delete();
      for (int i = 0; i < c * r; i++) q.push_back(rnd_word());
      run_frame(c, r, int'($urandom_range(0, 3)), f[0], q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
